// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: FIFO-buffered, diagonally skewed A/W feeder for the systolic array with a tile FSM
module sa_tile_sequencer #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int INWIDTH    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int KWIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic [KWIDTH-1:0]       i_k_len,
    output logic                    o_busy,
    input  logic                    i_a_valid,
    output logic                    o_a_ready,
    input  logic [ROWS*INWIDTH-1:0] i_a_data,
    input  logic                    i_w_valid,
    output logic                    o_w_ready,
    input  logic [COLS*INWIDTH-1:0] i_w_data,
    output logic                    o_fire,
    output logic                    o_acc_clr,
    output logic [ROWS*INWIDTH-1:0] o_arr_a,
    output logic [COLS*INWIDTH-1:0] o_arr_w,
    output logic                    o_tile_done,
    input  logic                    i_done_ack
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(ROWS + COLS);
    localparam int D  = ROWS + COLS - 2;
    localparam logic [AW:0]       P1 = 1;
    localparam logic [KWIDTH-1:0] K1 = 1;
    localparam logic [DW-1:0]     D1 = 1;
    localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_FEED = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4;

    logic [2:0]              r_state;
    logic [KWIDTH-1:0]       r_rem;
    logic [DW-1:0]           r_drn;
    logic [ROWS*INWIDTH-1:0] r_a_mem [FIFO_DEPTH];
    logic [COLS*INWIDTH-1:0] r_w_mem [FIFO_DEPTH];
    logic [AW:0]             r_a_wp, r_a_rp, r_w_wp, r_w_rp;
    logic                    w_a_empty, w_a_full, w_w_empty, w_w_full, w_a_push, w_w_push;
    logic                    w_feed, w_fire, w_pop;
    logic [ROWS*INWIDTH-1:0] w_a_inj;
    logic [COLS*INWIDTH-1:0] w_w_inj;

    assign w_a_empty = r_a_wp == r_a_rp;
    assign w_w_empty = r_w_wp == r_w_rp;
    assign w_a_full  = (r_a_wp[AW] != r_a_rp[AW]) && (r_a_wp[AW-1:0] == r_a_rp[AW-1:0]);
    assign w_w_full  = (r_w_wp[AW] != r_w_rp[AW]) && (r_w_wp[AW-1:0] == r_w_rp[AW-1:0]);
    assign w_a_push  = i_a_valid && !w_a_full;
    assign w_w_push  = i_w_valid && !w_w_full;
    assign w_feed    = r_state == S_FEED;
    assign w_fire    = w_feed ? (!w_a_empty && !w_w_empty) : (r_state == S_DRAIN);
    assign w_pop     = w_feed && w_fire;
    assign w_a_inj   = w_feed ? r_a_mem[r_a_rp[AW-1:0]] : '0;
    assign w_w_inj   = w_feed ? r_w_mem[r_w_rp[AW-1:0]] : '0;

    assign o_a_ready   = !w_a_full;
    assign o_w_ready   = !w_w_full;
    assign o_fire      = w_fire;
    assign o_busy      = r_state != S_IDLE;
    assign o_acc_clr   = r_state == S_CLEAR;
    assign o_tile_done = r_state == S_DONE;

    // FIFO pointers: pushes accepted in any state, A and W pop together on feed fires
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_a_wp <= '0;
            r_a_rp <= '0;
            r_w_wp <= '0;
            r_w_rp <= '0;
        end else begin
            if (w_a_push) r_a_wp <= r_a_wp + P1;
            if (w_w_push) r_w_wp <= r_w_wp + P1;
            if (w_pop) begin
                r_a_rp <= r_a_rp + P1;
                r_w_rp <= r_w_rp + P1;
            end
        end
    end

    // FIFO storage, no reset needed since the pointers gate every read
    always_ff @(posedge clk) begin
        if (w_a_push) r_a_mem[r_a_wp[AW-1:0]] <= i_a_data;
        if (w_w_push) r_w_mem[r_w_wp[AW-1:0]] <= i_w_data;
    end

    // tile FSM: K is latched at start so later k_len changes do not matter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_drn   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state <= S_CLEAR;
                    r_rem   <= i_k_len;
                end
                S_CLEAR: begin
                    r_state <= (r_rem == '0) ? S_DONE : S_FEED;
                    r_drn   <= DW'(D);
                end
                S_FEED: if (w_fire) begin
                    r_rem <= r_rem - K1;
                    if (r_rem == K1) r_state <= (D == 0) ? S_DONE : S_DRAIN;
                end
                S_DRAIN: begin
                    r_drn <= r_drn - D1;
                    if (r_drn == D1) r_state <= S_DONE;
                end
                S_DONE: if (i_done_ack) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_a
        if (r == 0) begin : g_l0
            assign o_arr_a[0 +: INWIDTH] = w_fire ? w_a_inj[0 +: INWIDTH] : '0;
        end else begin : g_ch
            logic [r*INWIDTH-1:0] r_sr;
            // r-stage delay line for A lane r, advancing only on fire
            always_ff @(posedge clk) begin
                if (!rstn || r_state == S_CLEAR) r_sr <= '0;
                else if (w_fire) r_sr <= (r_sr << INWIDTH) | (r*INWIDTH)'(w_a_inj[r*INWIDTH +: INWIDTH]);
            end
            assign o_arr_a[r*INWIDTH +: INWIDTH] = r_sr[r*INWIDTH-1 -: INWIDTH];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_w
        if (c == 0) begin : g_l0
            assign o_arr_w[0 +: INWIDTH] = w_fire ? w_w_inj[0 +: INWIDTH] : '0;
        end else begin : g_ch
            logic [c*INWIDTH-1:0] r_sr;
            // c-stage delay line for W lane c, advancing only on fire
            always_ff @(posedge clk) begin
                if (!rstn || r_state == S_CLEAR) r_sr <= '0;
                else if (w_fire) r_sr <= (r_sr << INWIDTH) | (c*INWIDTH)'(w_w_inj[c*INWIDTH +: INWIDTH]);
            end
            assign o_arr_w[c*INWIDTH +: INWIDTH] = r_sr[c*INWIDTH-1 -: INWIDTH];
        end
    end
endmodule
